// File: rtl/hdmi_pkg.sv
// Shared types and sizing helpers for the HDMI serializer PLL supervisor.
package hdmi_pkg;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_e;

  // The shared counter only ever compares against (param - 1), so clog2 of the
  // largest timing parameter is enough; never narrower than one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/hdmi_pll_supervisor_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  // Shift the raw level through two flops; only q may be used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {q, meta} <= 2'b00;
    else        {q, meta} <= {meta, d};
  end
endmodule

// File: rtl/hdmi_pll_supervisor.sv
// Sequences the HDMI serializer PLL: reset pulse, lock wait with retries,
// lock qualification, and downstream reset release once the lock is stable.
module hdmi_pll_supervisor
  import hdmi_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 2500,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_lock,
  output logic       pll_resetb,
  output logic [3:0] pll_delay,
  input  logic       delay_wr,
  input  logic [3:0] delay_val,
  input  logic       restart,
  output logic       out_reset_n,
  output logic       ready,
  output logic       failed,
  output logic [7:0] lock_losses
);
  localparam int            CW         = cnt_width(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] HOLD_END   = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_END   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_END = CW'(STABLE_CYCLES - 1);
  localparam logic [4:0]    MAX_R      = 5'(MAX_RETRIES);

  pll_state_e    state, nxt;
  logic [CW-1:0] cnt;
  logic [4:0]    retry, retry_nxt;
  logic          lock_s, strobe, cnt_clr, loss, run_hold;

  sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign strobe   = delay_wr | restart;
  assign cnt_clr  = strobe || (nxt != state);
  assign loss     = (state == RUN) && !lock_s && !strobe;
  // Downstream release rises one cycle after RUN is entered but drops on the
  // same edge that RUN is left.
  assign run_hold = (state == RUN) && (nxt == RUN);

  // Next-state and retry bookkeeping; a strobe overrides any FSM transition.
  always_comb begin
    nxt       = state;
    retry_nxt = retry;
    case (state)
      HOLD: begin
        if (cnt == HOLD_END) nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) nxt = STABLE;
        else if (cnt == LOCK_END) begin
          retry_nxt = retry + 5'd1;
          nxt       = (retry_nxt > MAX_R) ? FAIL : HOLD;
        end
      end
      STABLE: begin
        if (!lock_s) nxt = WAIT_LOCK;
        else if (cnt == STABLE_END) begin
          nxt       = RUN;
          retry_nxt = '0;
        end
      end
      RUN: begin
        if (!lock_s) nxt = HOLD;
      end
      FAIL:    nxt = FAIL;
      default: nxt = HOLD;
    endcase
    if (strobe) begin
      nxt       = HOLD;
      retry_nxt = (restart || state == FAIL) ? 5'd0 : retry;
    end
  end

  // State, shared cycle counter, retry count and delay setting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= HOLD;
      cnt       <= '0;
      retry     <= '0;
      pll_delay <= '0;
    end else begin
      state <= nxt;
      retry <= retry_nxt;
      cnt   <= cnt_clr ? '0 : cnt + CW'(1);
      if (delay_wr) pll_delay <= delay_val;
    end
  end

  // Registered control outputs; PLL reset and fail flag track the state edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pll_resetb  <= 1'b0;
      failed      <= 1'b0;
      ready       <= 1'b0;
      out_reset_n <= 1'b0;
    end else begin
      pll_resetb  <= !(nxt == HOLD || nxt == FAIL);
      failed      <= (nxt == FAIL);
      ready       <= run_hold;
      out_reset_n <= run_hold;
    end
  end

  // Saturating count of lock losses while running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          lock_losses <= '0;
    else if (loss && lock_losses != 8'hFF) lock_losses <= lock_losses + 8'd1;
  end
endmodule

// File: tb/tb_hdmi_pll_supervisor.sv
// Self-checking bench for hdmi_pll_supervisor with short timing parameters.
module tb_hdmi_pll_supervisor;
  localparam int RC = 4, LT = 20, SC = 8, MR = 2;
  // Reset release to ready when the PLL locks as soon as it leaves reset.
  localparam int MIN_LAT = RC + 2 + 1 + SC + 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_lock;
  logic       pll_resetb;
  logic [3:0] pll_delay;
  logic       delay_wr, restart;
  logic [3:0] delay_val;
  logic       out_reset_n, ready, failed;
  logic [7:0] lock_losses;

  always #5 clk = ~clk;

  hdmi_pll_supervisor #(
    .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_lock(pll_lock), .pll_resetb(pll_resetb),
    .pll_delay(pll_delay), .delay_wr(delay_wr), .delay_val(delay_val),
    .restart(restart), .out_reset_n(out_reset_n), .ready(ready),
    .failed(failed), .lock_losses(lock_losses)
  );

  // PLL lock model: lock rises lock_dly cycles after RESETB is released.
  logic lock_on = 1'b0, lock_kill = 1'b0;
  int   lock_dly = 1;
  int   lk_cnt = 0;
  always @(negedge clk) begin
    if (!pll_resetb)       lk_cnt <= 0;
    else if (lk_cnt < 1000) lk_cnt <= lk_cnt + 1;
  end
  assign pll_lock = lock_on && !lock_kill && (lk_cnt >= lock_dly);

  int n_chk = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: snapshot of all outputs expected after a given clock edge.
  typedef struct {
    string      name;
    int         due;
    logic [3:0] dly;
    logic       rdy, orn, rb, fl;
    logic [7:0] ll;
  } exp_t;
  exp_t sbq[$];

  task automatic expect_next(input string nm, input logic [3:0] d, input logic rdy,
                             input logic orn, input logic rb, input logic fl,
                             input logic [7:0] ll);
    exp_t e;
    e.name = nm; e.due = cyc + 1; e.dly = d;
    e.rdy = rdy; e.orn = orn; e.rb = rb; e.fl = fl; e.ll = ll;
    sbq.push_back(e);
  endtask

  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    cyc++;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk({e.name, "_delay"},  pll_delay,   e.dly);
      chk({e.name, "_ready"},  ready,       e.rdy);
      chk({e.name, "_outrst"}, out_reset_n, e.orn);
      chk({e.name, "_resetb"}, pll_resetb,  e.rb);
      chk({e.name, "_failed"}, failed,      e.fl);
      chk({e.name, "_losses"}, lock_losses, e.ll);
    end
  end

  logic [7:0] exp_ll = 8'd0;

  // One-cycle strobe; expects the PLL held in reset and outputs dropped next edge.
  task automatic strobe(input string nm, input logic wr, input logic [3:0] val,
                        input logic rs, input logic [3:0] exp_d);
    @(negedge clk);
    delay_wr = wr; delay_val = val; restart = rs;
    expect_next(nm, exp_d, 1'b0, 1'b0, 1'b0, 1'b0, exp_ll);
    @(posedge clk); #1;
    delay_wr = 1'b0; restart = 1'b0;
  endtask

  task automatic wait_rdy(input string nm, input logic lvl, input int budget, output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (ready !== lvl && n < budget);
    if (ready !== lvl) begin
      n_chk++; n_fail++;
      $display("FAIL %s: ready stayed %0d, wanted %0d within %0d cycles", nm, ready, lvl, budget);
    end
  endtask

  // Counts consecutive low samples of pll_resetb starting with the current one.
  task automatic count_low(output int len);
    len = 0;
    while (pll_resetb === 1'b0 && len < 50) begin len++; @(posedge clk); #1; end
  endtask

  typedef struct {
    string      name;
    logic       wr;
    logic [3:0] val;
    logic       rs;
    logic [3:0] exp_d;
  } vec_t;
  vec_t vt[4];

  initial begin : main
    int n, len, pulses;
    vt[0] = '{"dwr_A",    1'b1, 4'hA, 1'b0, 4'hA};
    vt[1] = '{"rst_only", 1'b0, 4'h3, 1'b1, 4'hA};
    vt[2] = '{"both_5",   1'b1, 4'h5, 1'b1, 4'h5};
    vt[3] = '{"dwr_C",    1'b1, 4'hC, 1'b0, 4'hC};

    reset_n = 1'b0; delay_wr = 1'b0; delay_val = 4'h0; restart = 1'b0;
    lock_on = 1'b1; lock_dly = 5;
    repeat (2) @(negedge clk);
    expect_next("reset_state", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // 1: lock shows up 5 cycles after RESETB rises, i.e. 4 later than minimum
    @(negedge clk); reset_n = 1'b1;
    wait_rdy("t1", 1'b1, 100, n);
    chk("t1_latency", n, MIN_LAT + 4);
    chk("t1_resetb", pll_resetb, 1);
    chk("t1_outrst", out_reset_n, 1);
    chk("t1_failed", failed, 0);

    // 1b: immediate lock gives the minimum latency
    @(negedge clk); reset_n = 1'b0; lock_dly = 1;
    @(negedge clk); reset_n = 1'b1;
    wait_rdy("t1b", 1'b1, 100, n);
    chk("t1b_min_latency", n, MIN_LAT);

    // 2: no lock at all -> MR+1 reset pulses, then FAIL
    lock_on = 1'b0;
    strobe("t2_restart", 1'b0, 4'h0, 1'b1, 4'h0);
    pulses = 0; len = 0; n = 0;
    while (failed !== 1'b1 && n < 300) begin
      if (pll_resetb === 1'b0) len++;
      else if (len > 0) begin pulses++; chk("t2_pulse_len", len, RC); len = 0; end
      @(posedge clk); #1; n++;
    end
    chk("t2_failed", failed, 1);
    chk("t2_pulses", pulses, MR + 1);
    chk("t2_resetb_fail", pll_resetb, 0);
    repeat (30) @(posedge clk);
    #1 chk("t2_fail_sticky", failed, 1);
    lock_on = 1'b1;
    strobe("t2_leave_fail", 1'b0, 4'h0, 1'b1, 4'h0);
    count_low(len);
    chk("t2_relock_pulse", len, RC);
    wait_rdy("t2_relock", 1'b1, 100, n);

    // 3: 1-cycle lock glitch at STABLE count 5 costs 6 STABLE + 1 WAIT_LOCK cycles
    @(negedge clk); reset_n = 1'b0; exp_ll = 8'd0;
    @(negedge clk); reset_n = 1'b1;
    fork
      begin
        repeat (10) @(posedge clk);
        @(negedge clk); lock_kill = 1'b1;
        @(negedge clk); lock_kill = 1'b0;
      end
    join_none
    wait_rdy("t3", 1'b1, 100, n);
    chk("t3_glitch_latency", n, MIN_LAT + 7);

    // 4: lock loss in RUN
    @(negedge clk); lock_on = 1'b0;
    wait_rdy("t4_drop", 1'b0, 10, n);
    chk("t4_drop_within3", (n <= 3), 1);
    chk("t4_outrst_low", out_reset_n, 0);
    exp_ll = 8'd1;
    chk("t4_losses_1", lock_losses, exp_ll);
    @(negedge clk); lock_on = 1'b1;
    wait_rdy("t4_relock", 1'b1, 100, n);
    for (int i = 0; i < 299; i++) begin
      @(negedge clk); lock_on = 1'b0;
      wait_rdy("t4_drop_loop", 1'b0, 10, n);
      exp_ll = (exp_ll == 8'hFF) ? 8'hFF : exp_ll + 8'd1;
      @(negedge clk); lock_on = 1'b1;
      wait_rdy("t4_relock_loop", 1'b1, 100, n);
    end
    chk("t4_losses_sat", lock_losses, exp_ll);
    chk("t4_losses_255", lock_losses, 8'd255);

    // 5: strobe vectors applied from RUN
    for (int i = 0; i < 4; i++) begin
      strobe(vt[i].name, vt[i].wr, vt[i].val, vt[i].rs, vt[i].exp_d);
      count_low(len);
      chk({vt[i].name, "_pulse"}, len, RC);
      wait_rdy({vt[i].name, "_relock"}, 1'b1, 100, n);
      chk({vt[i].name, "_delay_kept"}, pll_delay, vt[i].exp_d);
    end

    // 6: asynchronous reset in the middle of STABLE
    strobe("t6_restart", 1'b0, 4'h0, 1'b1, 4'hC);
    repeat (9) @(posedge clk);
    #4 reset_n = 1'b0;
    #1;
    chk("t6_resetb",  pll_resetb,  0);
    chk("t6_delay",   pll_delay,   0);
    chk("t6_outrst",  out_reset_n, 0);
    chk("t6_ready",   ready,       0);
    chk("t6_failed",  failed,      0);
    chk("t6_losses",  lock_losses, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_rdy("t6_restart_seq", 1'b1, 100, n);
    chk("t6_latency", n, MIN_LAT);

    repeat (2) @(posedge clk);
    #2;
    if (sbq.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_chk);
    $fatal(1, "watchdog");
  end
endmodule
